// File: rtl/rx_stream_pkg.sv
// rtl/rx_stream_pkg.sv - shared constants and types for the I/Q byte streamer
package rx_stream_pkg;

  localparam int BYTES_PER_PAIR = 6;
  localparam int PAIR_W         = 48;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [2:0] byte_idx_t;

  localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_PAIR - 1);

endpackage

// File: rtl/iq_sync_fifo.sv
// rtl/iq_sync_fifo.sv - single-clock FIFO with full/empty/count and a combinational head read
module iq_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rx_iq_byte_stream.sv
// rtl/rx_iq_byte_stream.sv - buffers I/Q pairs and emits them as big-endian bytes
// Optional drop counter output enabled by RX_IQ_OVERFLOW_COUNT_EN.
module rx_iq_byte_stream
  import rx_stream_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_strobe,
  input  logic [SAMPLE_W-1:0]      in_data_I,
  input  logic [SAMPLE_W-1:0]      in_data_Q,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_first,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
`ifdef RX_IQ_OVERFLOW_COUNT_EN
  output logic [15:0]              overflow_count,
`endif
  input  logic                     overflow_clear
);

  state_t            state_q, state_d;
  byte_idx_t         idx_q, idx_d;
  logic [PAIR_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              first_q, first_d;
  logic              ovf_q, ovf_d;

  logic [PAIR_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              last_accept;
  logic              drop;

  assign last_accept = (state_q == SEND) && out_ready && (idx_q == LAST_BYTE_IDX);
  assign fifo_pop    = !fifo_empty && ((state_q == IDLE) || last_accept);
  assign drop        = in_strobe && fifo_full && !fifo_pop;

  iq_sync_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (in_strobe),
    .pop   (fifo_pop),
    .wdata ({in_data_I, in_data_Q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill_level)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    valid_d = valid_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          shift_d = fifo_rdata;
          idx_d   = '0;
          valid_d = 1'b1;
          first_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_BYTE_IDX) begin
            // Reload straight from the FIFO head so consecutive pairs have no gap.
            if (!fifo_empty) begin
              shift_d = fifo_rdata;
              idx_d   = '0;
              first_d = 1'b1;
            end else begin
              shift_d = '0;
              idx_d   = '0;
              valid_d = 1'b0;
              first_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q << 8;
            idx_d   = idx_q + 1'b1;
            first_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = overflow_clear ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      first_q <= first_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = shift_q[PAIR_W-1 -: 8];
  assign out_valid = valid_q;
  assign out_first = first_q;
  assign overflow  = ovf_q;

`ifdef RX_IQ_OVERFLOW_COUNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (overflow_clear)
      ovf_cnt_d = '0;
    else if (drop && (ovf_cnt_q != 16'hFFFF))
      ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ovf_cnt_q <= '0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign overflow_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_rx_iq_byte_stream.sv
// tb/tb_rx_iq_byte_stream.sv - scoreboard bench for rx_iq_byte_stream (DEPTH=4)
module tb_rx_iq_byte_stream;

  localparam int DEPTH = 4;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_strobe;
  logic [23:0]   in_data_I;
  logic [23:0]   in_data_Q;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic [FW-1:0] fill_level;
  logic          overflow;
  logic          overflow_clear;
`ifdef RX_IQ_OVERFLOW_COUNT_EN
  logic [15:0]   overflow_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  rx_iq_byte_stream #(.DEPTH(DEPTH), .SAMPLE_W(24)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_strobe      (in_strobe),
    .in_data_I      (in_data_I),
    .in_data_Q      (in_data_Q),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_first      (out_first),
    .fill_level     (fill_level),
    .overflow       (overflow),
`ifdef RX_IQ_OVERFLOW_COUNT_EN
    .overflow_count (overflow_count),
`endif
    .overflow_clear (overflow_clear)
  );

  always #5 clock = ~clock;

  // Every byte the consumer takes at the next rising edge is checked here.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_byte: got first=%0b data=%02h, expected nothing", out_first, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_first, out_data} !== mon_e) begin
          errors++;
          $display("FAIL stream_byte: got first=%0b data=%02h, expected first=%0b data=%02h",
                   out_first, out_data, mon_e[8], mon_e[7:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_pair(input logic [23:0] i, input logic [23:0] q);
    exp_q.push_back({1'b1, i[23:16]});
    exp_q.push_back({1'b0, i[15:8]});
    exp_q.push_back({1'b0, i[7:0]});
    exp_q.push_back({1'b0, q[23:16]});
    exp_q.push_back({1'b0, q[15:8]});
    exp_q.push_back({1'b0, q[7:0]});
  endtask

  task automatic strobe_pair(input logic [23:0] i, input logic [23:0] q, input bit stored);
    in_strobe = 1'b1;
    in_data_I = i;
    in_data_Q = q;
    if (stored) expect_pair(i, q);
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: %0d bytes outstanding, out_valid=%0b, expected 0 and 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_strobe = 1'b0; in_data_I = '0; in_data_Q = '0;
    out_ready = 1'b0; overflow_clear = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, out_first, out_data, fill_level, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b first=%0b data=%02h fill=%0d ovf=%0b, expected all 0",
               out_valid, out_first, out_data, fill_level, overflow);
    end
`ifdef RX_IQ_OVERFLOW_COUNT_EN
    checks++;
    if (overflow_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", overflow_count);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pair();
    out_ready = 1'b1;
    strobe_pair(24'h123456, 24'hABCDEF, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%0b one edge after strobe, expected 0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, out_first, out_data} !== {1'b1, 1'b1, 8'h12}) begin
      errors++;
      $display("FAIL latency_first: valid=%0b first=%0b data=%02h, expected 1 1 12", out_valid, out_first, out_data);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL throughput: out_valid=%0b at byte %0d, expected 1", out_valid, k);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_end: valid=%0b outstanding=%0d, expected 0 and 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    strobe_pair(24'h123456, 24'hABCDEF, 1'b1);
    tick(); tick(); tick(); tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({out_valid, out_first, out_data} !== {1'b1, 1'b0, 8'hAB}) begin
        errors++;
        $display("FAIL hold_byte3: valid=%0b first=%0b data=%02h, expected 1 0 AB", out_valid, out_first, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    // One pair moves to the output register, four fill the FIFO, the sixth is dropped.
    for (int k = 0; k < 6; k++)
      strobe_pair(24'h100000 + 24'(k), 24'h200000 + 24'(k), k < 5);
    checks++;
    if (fill_level !== FW'(DEPTH) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: fill=%0d ovf=%0b, expected %0d 1", fill_level, overflow, DEPTH);
    end
`ifdef RX_IQ_OVERFLOW_COUNT_EN
    checks++;
    if (overflow_count !== 16'd1) begin
      errors++;
      $display("FAIL overflow_count: got %0d expected 1", overflow_count);
    end
`endif
    out_ready = 1'b1;
    wait_drain(60);
    checks++;
    if (fill_level !== '0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: fill=%0d ovf=%0b, expected 0 1", fill_level, overflow);
    end
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_cleared: ovf=%0b expected 0", overflow);
    end
  endtask

  task automatic test_full_with_pop();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      strobe_pair(24'h300000 + 24'(k), 24'h400000 + 24'(k), 1'b1);
    out_ready = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    strobe_pair(24'h5A5A5A, 24'hC3C3C3, 1'b1);
    checks++;
    if (fill_level !== FW'(DEPTH) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_with_pop: fill=%0d ovf=%0b, expected %0d 0", fill_level, overflow, DEPTH);
    end
    wait_drain(80);
  endtask

  task automatic test_reset_mid_pair();
    out_ready = 1'b1;
    strobe_pair(24'h778899, 24'hAABBCC, 1'b1);
    tick(); tick(); tick(); tick(); tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_first, out_data, fill_level, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_async: valid=%0b first=%0b data=%02h fill=%0d ovf=%0b, expected all 0",
               out_valid, out_first, out_data, fill_level, overflow);
    end
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    strobe_pair(24'hE1E2E3, 24'hF4F5F6, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_first, out_data} !== {1'b1, 1'b1, 8'hE1}) begin
      errors++;
      $display("FAIL restart_byte0: valid=%0b first=%0b data=%02h, expected 1 1 E1", out_valid, out_first, out_data);
    end
    wait_drain(20);
  endtask

  task automatic test_overflow_clear();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      strobe_pair(24'h600000 + 24'(k), 24'h700000 + 24'(k), 1'b1);
    overflow_clear = 1'b1;
    strobe_pair(24'hDEADBE, 24'hEFEFEF, 1'b0);
    overflow_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0 || fill_level !== FW'(DEPTH)) begin
      errors++;
      $display("FAIL clear_priority: ovf=%0b fill=%0d, expected 0 %0d", overflow, fill_level, DEPTH);
    end
`ifdef RX_IQ_OVERFLOW_COUNT_EN
    checks++;
    if (overflow_count !== 16'd0) begin
      errors++;
      $display("FAIL clear_count: got %0d expected 0", overflow_count);
    end
`endif
    out_ready = 1'b1;
    wait_drain(60);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      strobe_pair(24'($urandom), 24'($urandom), 1'b1);
      repeat (5) tick();
    end
    checks++;
    if (overflow !== 1'b0 || fill_level > FW'(1)) begin
      errors++;
      $display("FAIL sustained: ovf=%0b fill=%0d, expected 0 and <=1", overflow, fill_level);
    end
    wait_drain(40);
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_backpressure();
    test_overflow();
    test_full_with_pop();
    test_reset_mid_pair();
    test_overflow_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
